// File: rtl/deskew_buffer_pkg.sv
// Shared types and defaults for the deskew buffer.
// Provides array geometry defaults, accumulator word type and FSM states.
package deskew_buffer_pkg;

    localparam int ARRAY_SIZE_DEF = 8;
    localparam int ACC_WIDTH_DEF  = 32;

    typedef logic signed [ACC_WIDTH_DEF-1:0] acc_t;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } deskew_state_t;

endpackage

// File: rtl/deskew_lane.sv
// One column lane of the deskew buffer: DEPTH-word store plus write counter.
// Ports: valid/data word in, accept (collecting), clear (restart counter),
//        rd_idx/rd_data row read, full (full after this edge), drop pulse.
module deskew_lane #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid,
    input  logic                       accept,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           data,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       drop
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count;
    logic             at_top;
    logic             write;

    assign at_top  = (count == CW'(DEPTH));
    assign write   = valid && accept && !at_top;
    assign drop    = valid && (!accept || at_top);
    // Counts the word landing this cycle so the FSM can leave FILL
    // on the same edge as the final write.
    assign full    = at_top || (write && count == CW'(DEPTH - 1));
    assign rd_data = mem[rd_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (write) begin
            count <= count + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write) begin
            mem[count[IW-1:0]] <= data;
        end
    end

endmodule

// File: rtl/deskew_buffer.sv
// Collects skewed per-lane result streams into a full tile, then
// presents it as aligned rows over valid/ready.
// Ports: clk, rst (async active-low), in_valid/data_in/in_ready lane side,
//        out_valid/out_ready/data_out/out_row/out_last row side, overflow.
module deskew_buffer
    import deskew_buffer_pkg::*;
#(
    parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [ARRAY_SIZE-1:0]                     in_valid,
    input  logic signed [ARRAY_SIZE-1:0][ACC_WIDTH-1:0] data_in,
    output logic                                      in_ready,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic signed [ARRAY_SIZE-1:0][ACC_WIDTH-1:0] data_out,
    output logic [$clog2(ARRAY_SIZE)-1:0]             out_row,
    output logic                                      out_last,
    output logic                                      overflow
);

    localparam int PW = $clog2(ARRAY_SIZE);

    deskew_state_t state;
    logic [PW-1:0] rd_ptr;

    logic [ARRAY_SIZE-1:0]                lane_full;
    logic [ARRAY_SIZE-1:0]                lane_drop;
    logic [ARRAY_SIZE-1:0][ACC_WIDTH-1:0] rows;

    logic filling;
    logic at_last;
    logic xfer;
    logic wrap;

    assign filling = (state == FILL);
    assign at_last = (rd_ptr == PW'(ARRAY_SIZE - 1));
    assign xfer    = !filling && out_ready;
    assign wrap    = xfer && at_last;

    assign in_ready  = filling;
    assign out_valid = !filling;
    assign out_row   = rd_ptr;
    assign out_last  = !filling && at_last;
    assign data_out  = rows;

    for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_lane
        deskew_lane #(
            .DEPTH (ARRAY_SIZE),
            .WIDTH (ACC_WIDTH)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .valid   (in_valid[j]),
            .accept  (filling),
            .clear   (wrap),
            .data    (data_in[j]),
            .rd_idx  (rd_ptr),
            .rd_data (rows[j]),
            .full    (lane_full[j]),
            .drop    (lane_drop[j])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= FILL;
            rd_ptr <= '0;
        end else begin
            unique case (state)
                FILL: begin
                    if (&lane_full) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (wrap) begin
                        state  <= FILL;
                        rd_ptr <= '0;
                    end else if (xfer) begin
                        rd_ptr <= rd_ptr + PW'(1);
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (|lane_drop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_deskew_buffer.sv
// Randomized self-checking bench for deskew_buffer (4x4 tile, 32-bit words).
// Reference: per-lane queues of accepted words and a fill/drain phase flag.
module tb_deskew_buffer;

    localparam int N = 4;

    logic                 clk;
    logic                 rst;
    logic [N-1:0]         in_valid;
    logic [N-1:0][31:0]   data_in;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [N-1:0][31:0]   data_out;
    logic [1:0]           out_row;
    logic                 out_last;
    logic                 overflow;

    deskew_buffer #(
        .ARRAY_SIZE (N),
        .ACC_WIDTH  (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_row   (out_row),
        .out_last  (out_last),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int  m_q [N][$];
    bit  m_drain;
    int  m_row;
    bit  m_ovf;
    bit  last_ov;

    task automatic check(input string tag,
                         input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int j = 0; j < N; j++) m_q[j].delete();
        m_drain = 0;
        m_row   = 0;
        m_ovf   = 0;
    endtask

    // Called at posedge+1; drives one cycle, checks at negedge,
    // advances the model across the following rising edge.
    task automatic cycle(input logic [N-1:0] v,
                         input logic [N-1:0][31:0] d,
                         input logic rdy);
        bit all4;
        in_valid  = v;
        data_in   = d;
        out_ready = rdy;
        @(negedge clk);
        last_ov = out_valid;
        check("in_ready", {31'b0, in_ready}, {31'b0, !m_drain});
        check("out_valid", {31'b0, out_valid}, {31'b0, m_drain});
        check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
        if (m_drain) begin
            check("out_row", {30'b0, out_row}, m_row);
            check("out_last", {31'b0, out_last}, (m_row == N - 1) ? 1 : 0);
            for (int j = 0; j < N; j++)
                check("data", data_out[j], m_q[j][m_row]);
        end
        for (int j = 0; j < N; j++) begin
            if (v[j]) begin
                if (!m_drain && m_q[j].size() < N) m_q[j].push_back(int'(d[j]));
                else m_ovf = 1;
            end
        end
        if (m_drain) begin
            if (rdy) begin
                if (m_row == N - 1) begin
                    m_drain = 0;
                    m_row   = 0;
                    for (int j = 0; j < N; j++) m_q[j].delete();
                end else begin
                    m_row++;
                end
            end
        end else begin
            all4 = 1;
            for (int j = 0; j < N; j++) if (m_q[j].size() != N) all4 = 0;
            if (all4) m_drain = 1;
        end
        @(posedge clk);
        #1;
    endtask

    // mode 0: minimal skew, values 10k+j; mode 1: random gaps, -5..+5.
    task automatic run_tile(input int mode, input int stall_row,
                            input bit junk_last, input bit extra,
                            input int abort_row);
        int w [N][N];
        int idx [N];
        int stall_cnt;
        int first_v;
        bit extra_done;
        bit done;
        bit was_drain;
        logic [N-1:0] v;
        logic [N-1:0][31:0] d;
        logic rdy;
        for (int j = 0; j < N; j++) begin
            idx[j] = 0;
            for (int k = 0; k < N; k++)
                w[j][k] = (mode == 0) ? 10 * k + j
                                      : int'($urandom_range(10)) - 5;
        end
        stall_cnt  = 0;
        first_v    = -1;
        extra_done = 0;
        done       = 0;
        for (int t = 0; t < 300; t++) begin
            if (m_drain && m_row == abort_row) return;
            v   = '0;
            d   = '0;
            rdy = 1'b1;
            if (!m_drain) begin
                for (int j = 0; j < N; j++) begin
                    if (idx[j] < N &&
                        (mode == 0 ? t >= j : $urandom_range(1) == 1)) begin
                        v[j] = 1'b1;
                        d[j] = w[j][idx[j]];
                        idx[j]++;
                    end else if (extra && j == 2 && idx[j] == N && !extra_done) begin
                        v[j] = 1'b1;
                        d[j] = 32'd999;
                        extra_done = 1;
                    end
                end
                rdy = 1'($urandom_range(1));
            end else begin
                if (m_row == stall_row && stall_cnt < 5) begin
                    rdy = 1'b0;
                    stall_cnt++;
                end else if (mode == 1) begin
                    rdy = 1'($urandom_range(1));
                end
                if (extra) begin
                    v = N'($urandom_range(15));
                    d = {$urandom, $urandom, $urandom, $urandom};
                end
                if (junk_last && m_row == N - 1 && rdy) begin
                    v = '1;
                    d = {32'd77, 32'd77, 32'd77, 32'd77};
                end
            end
            was_drain = m_drain;
            cycle(v, d, rdy);
            if (last_ov && first_v < 0) first_v = t;
            if (was_drain && !m_drain) begin
                done = 1;
                break;
            end
        end
        check("tile_done", {31'b0, done}, 1);
        if (mode == 0) check("fill_lat", first_v, 7);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        check("rst_in_ready", {31'b0, in_ready}, 1);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_out_row", {30'b0, out_row}, 0);
        check("rst_out_last", {31'b0, out_last}, 0);
        check("rst_overflow", {31'b0, overflow}, 0);
        for (int j = 0; j < N; j++) check("rst_data", data_out[j], 0);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = '0;
        data_in   = '0;
        out_ready = 1'b0;
        model_clear();
        #12;
        do_reset();
        run_tile(0, -1, 0, 0, -1);
        run_tile(0, 1, 0, 0, -1);
        for (int r = 0; r < 4; r++) run_tile(1, -1, 0, 0, -1);
        run_tile(0, -1, 1, 0, -1);
        run_tile(0, -1, 0, 0, -1);
        check("b2b_overflow", {31'b0, overflow}, 1);
        run_tile(1, 2, 0, 1, -1);
        check("sticky_overflow", {31'b0, overflow}, 1);
        run_tile(0, -1, 0, 0, 2);
        check("abort_at_row2", {30'b0, out_row}, 2);
        do_reset();
        run_tile(0, -1, 0, 0, -1);
        run_tile(1, 0, 0, 0, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
